// File: rtl/gf_word_pkg.sv
// Shared definitions for the gigafitter word transmitter: bus width, EE tag, FSM states.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package gf_word_pkg;

    localparam int         WORD_W = 23;
    localparam logic [1:0] EE_TAG = 2'b11;
    localparam int         EE_MSB = 22;
    localparam int         EE_LSB = 21;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RECOVER = 3'd3,
        ST_GAP     = 3'd4
    } tx_state_t;

    // End-of-event words carry the EE tag in their two top bits.
    function automatic logic is_ee(input logic [WORD_W-1:0] word);
        return word[EE_MSB:EE_LSB] == EE_TAG;
    endfunction

endpackage

// File: rtl/gf_sync_fifo.sv
// Single-clock word FIFO with registered pointers and combinational head read.
// Latency: a push is visible as not-empty (and at dout) the cycle after it.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
//
// Ports: clk/rst_n clock and async active-low reset (flushes the FIFO);
//        push/din write side, pop/dout read side, empty/full status.
module gf_sync_fifo #(
    parameter int WORD_W  = 23,
    parameter int FIFO_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

    logic [WORD_W-1:0] mem [2**FIFO_AW];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [FIFO_AW:0]  wr_ptr;
    logic [FIFO_AW:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot this same cycle, so a push into a full FIFO is kept.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= din;
    end

endmodule

// File: rtl/gf_word_tx.sv
// Gigafitter word-bus transmitter: queues words and drives DATA_OUT with a timed active-low DS_N strobe.
// Latency: push at cycle 0 -> DATA_OUT valid cycle 2 -> DS_N low cycle 3; back-to-back words every 3 cycles.
// Backpressure: HOLD stalls the start of a new word only; a started word always completes; EE words add an idle gap.
//
// Ports: J3WRITECLK/RST_N clock and async active-low reset; wr_en/wr_data push side with
//        fifo_full and sticky overflow; HOLD receiver backpressure; DATA_OUT/DS_N bus;
//        busy, word_cnt, ev_cnt status.
module gf_word_tx
    import gf_word_pkg::*;
#(
    parameter int FIFO_AW   = 4,
    parameter int SETUP_CYC = 1,
    parameter int LOW_CYC   = 1,
    parameter int HIGH_CYC  = 1,
    parameter int EE_GAP    = 14
) (
    input  logic              J3WRITECLK,
    input  logic              RST_N,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    output logic              fifo_full,
    output logic              overflow,
    input  logic              HOLD,
    output logic [WORD_W-1:0] DATA_OUT,
    output logic              DS_N,
    output logic              busy,
    output logic [15:0]       word_cnt,
    output logic [15:0]       ev_cnt
);

    localparam bit          GAP_EN    = (EE_GAP > 0);
    localparam logic [15:0] SETUP_LD  = 16'(SETUP_CYC - 1);
    localparam logic [15:0] LOW_LD    = 16'(LOW_CYC - 1);
    localparam logic [15:0] HIGH_LD   = 16'(HIGH_CYC - 1);
    localparam logic [15:0] GAP_LD    = GAP_EN ? 16'(EE_GAP - 1) : 16'd0;

    tx_state_t         state;
    logic [15:0]       phase;      // cycles left in the current timed state, minus one
    logic              cur_ee;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_dout;
    logic              can_start;
    logic              phase_done;
    logic              pop;

    gf_sync_fifo #(
        .WORD_W  (WORD_W),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (J3WRITECLK),
        .rst_n (RST_N),
        .push  (wr_en),
        .pop   (pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign can_start  = !fifo_empty && !HOLD;
    assign phase_done = (phase == 16'd0);
    assign busy       = (state != ST_IDLE) || !fifo_empty;

    // The IDLE decision is folded into the last RECOVER/GAP cycle, so a queued word
    // starts without a dead IDLE cycle and back-to-back words take SETUP+LOW+HIGH cycles.
    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE:    pop = can_start;
            ST_RECOVER: pop = phase_done && !(cur_ee && GAP_EN) && can_start;
            ST_GAP:     pop = phase_done && can_start;
            default:    pop = 1'b0;
        endcase
    end

    always_ff @(posedge J3WRITECLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            phase    <= 16'd0;
            cur_ee   <= 1'b0;
            DATA_OUT <= '0;
            DS_N     <= 1'b1;
            word_cnt <= 16'd0;
            ev_cnt   <= 16'd0;
        end else begin
            case (state)
                ST_SETUP: begin
                    if (phase_done) begin
                        state    <= ST_STROBE;
                        phase    <= LOW_LD;
                        DS_N     <= 1'b0;
                        word_cnt <= word_cnt + 16'd1;
                        if (cur_ee) ev_cnt <= ev_cnt + 16'd1;
                    end else begin
                        phase <= phase - 16'd1;
                    end
                end
                ST_STROBE: begin
                    if (phase_done) begin
                        state <= ST_RECOVER;
                        phase <= HIGH_LD;
                        DS_N  <= 1'b1;
                    end else begin
                        phase <= phase - 16'd1;
                    end
                end
                ST_RECOVER: begin
                    if (phase_done) begin
                        if (cur_ee && GAP_EN) begin
                            state <= ST_GAP;
                            phase <= GAP_LD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        phase <= phase - 16'd1;
                    end
                end
                ST_GAP: begin
                    if (phase_done) state <= ST_IDLE;
                    else            phase <= phase - 16'd1;
                end
                default: state <= ST_IDLE;
            endcase

            // Starting a word overrides the transitions above; pop only fires
            // in IDLE or at the final cycle of RECOVER/GAP.
            if (pop) begin
                DATA_OUT <= fifo_dout;
                cur_ee   <= is_ee(fifo_dout);
                state    <= ST_SETUP;
                phase    <= SETUP_LD;
            end
        end
    end

    // Sticky until reset; a push into a full FIFO with a concurrent pop is not lost.
    always_ff @(posedge J3WRITECLK or negedge RST_N) begin
        if (!RST_N)                        overflow <= 1'b0;
        else if (wr_en && fifo_full && !pop) overflow <= 1'b1;
    end

endmodule

// File: tb/tb_gf_word_tx.sv
// Self-checking bench for gf_word_tx: directed scenarios plus a randomized run against a queue model.
// Latency: not applicable.
// Backpressure: HOLD driven by the scenarios.
module tb_gf_word_tx;

    localparam int GAP = 14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [22:0] wr_data = '0;
    logic        hold = 1'b0;
    logic        fifo_full, overflow, ds_n, busy;
    logic [22:0] data_out;
    logic [15:0] word_cnt, ev_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Observed strobe falling edges: cycle index and the data on the bus at that moment.
    int          fall_cyc[$];
    logic [22:0] fall_dat[$];
    int          unstable = 0;
    logic        ds_prev = 1'b1;
    logic [22:0] dat_prev = '0;

    gf_word_tx dut (
        .J3WRITECLK (clk),
        .RST_N      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .HOLD       (hold),
        .DATA_OUT   (data_out),
        .DS_N       (ds_n),
        .busy       (busy),
        .word_cnt   (word_cnt),
        .ev_cnt     (ev_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ds_prev && !ds_n) begin
            fall_cyc.push_back(cyc);
            fall_dat.push_back(data_out);
            if (data_out !== dat_prev) unstable++;
        end
        ds_prev  = ds_n;
        dat_prev = data_out;
    end

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic bit word_is_ee(input logic [22:0] w);
        return (w >> 21) == 23'd3;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [22:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        hold  = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        fall_cyc.delete();
        fall_dat.delete();
        unstable = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        n_tests++;
        if ({data_out, ds_n, fifo_full, overflow, busy} !== {23'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got data %h ds_n %b full %b ovf %b busy %b, want 0 1 0 0 0",
                     data_out, ds_n, fifo_full, overflow, busy);
        end
        n_tests++;
        if (word_cnt !== 16'd0 || ev_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counts: got %0d/%0d, want 0/0", word_cnt, ev_cnt);
        end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_single();
        int c0;
        do_reset();
        c0 = cyc;
        push(23'h00cc0c);
        tick(1);   // cycle c0+2
        n_tests++;
        if (data_out !== 23'h00cc0c || ds_n !== 1'b1) begin
            n_fail++;
            $display("FAIL single_setup: got data %h ds_n %b, want 00cc0c 1", data_out, ds_n);
        end
        tick(1);   // cycle c0+3
        n_tests++;
        if (ds_n !== 1'b0) begin
            n_fail++;
            $display("FAIL single_strobe: got ds_n %b, want 0", ds_n);
        end
        tick(1);   // cycle c0+4
        n_tests++;
        if (ds_n !== 1'b1 || word_cnt !== 16'd1 || ev_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL single_after: got ds_n %b cnt %0d/%0d, want 1 1/0", ds_n, word_cnt, ev_cnt);
        end
        tick(3);
        n_tests++;
        if (fall_cyc.size() != 1 || fall_cyc[0] != c0 + 3 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_fall: got %0d falls busy %b, want 1 fall at cycle %0d busy 0",
                     fall_cyc.size(), busy, c0 + 3);
        end
    endtask

    task automatic test_burst();
        logic [22:0] w[5];
        int          pc[5];
        int          exp_c[5];
        int          prev;
        bit          pee;
        int          c0;
        w[0] = 23'h00cc0c; w[1] = 23'h0539da; w[2] = 23'h081a25; w[3] = 23'h600001; w[4] = 23'h012345;
        do_reset();
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            pc[i] = cyc;
            push(w[i]);
        end
        tick(1);
        pc[4] = cyc;          // queued during the EE gap
        push(w[4]);
        tick(8);              // cycle c0+14: four words out, fifth still waiting
        n_tests++;
        if (word_cnt !== 16'd4 || ev_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL burst_counts: got %0d/%0d, want 4/1", word_cnt, ev_cnt);
        end
        prev = -100;
        pee  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_c[i] = imax(pc[i] + 3, prev + 3 + (pee ? GAP : 0));
            prev = exp_c[i];
            pee  = word_is_ee(w[i]);
        end
        tick(exp_c[4] - c0 - 14 + 3);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (i >= fall_cyc.size()) begin
                n_fail++;
                $display("FAIL burst_fall[%0d]: got no strobe, want cycle %0d", i, exp_c[i] - c0);
            end else if (fall_cyc[i] != exp_c[i] || fall_dat[i] !== w[i]) begin
                n_fail++;
                $display("FAIL burst_fall[%0d]: got cycle %0d data %h, want cycle %0d data %h",
                         i, fall_cyc[i] - c0, fall_dat[i], exp_c[i] - c0, w[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [22:0] w[3];
        int          h;
        int          e;
        w[0] = 23'h000111; w[1] = 23'h222222; w[2] = 23'h133333;
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) push(w[i]);
        tick(20);
        n_tests++;
        if (fall_cyc.size() != 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_blocks: got %0d falls busy %b, want 0 falls busy 1", fall_cyc.size(), busy);
        end
        h = cyc;
        hold = 1'b0;
        tick(15);
        for (int i = 0; i < 3; i++) begin
            e = h + 2 + 3 * i;
            n_tests++;
            if (i >= fall_cyc.size()) begin
                n_fail++;
                $display("FAIL hold_release[%0d]: got no strobe, want data %h", i, w[i]);
            end else if (fall_cyc[i] != e || fall_dat[i] !== w[i]) begin
                n_fail++;
                $display("FAIL hold_release[%0d]: got cycle %0d data %h, want cycle %0d data %h",
                         i, fall_cyc[i] - h, fall_dat[i], e - h, w[i]);
            end
        end

        // HOLD rising while the strobe is low: the pulse completes, the next word waits.
        do_reset();
        push(23'h0000aa);
        push(23'h0000bb);
        tick(1);              // strobe cycle of the first word
        hold = 1'b1;
        n_tests++;
        if (ds_n !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_mid_strobe: got ds_n %b, want 0", ds_n);
        end
        tick(1);
        n_tests++;
        if (ds_n !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_pulse_end: got ds_n %b, want 1", ds_n);
        end
        tick(10);
        n_tests++;
        if (fall_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL hold_next_waits: got %0d falls, want 1", fall_cyc.size());
        end
        h = cyc;
        hold = 1'b0;
        tick(6);
        n_tests++;
        if (fall_cyc.size() != 2 || fall_cyc[1] != h + 2 || fall_dat[1] !== 23'h0000bb) begin
            n_fail++;
            $display("FAIL hold_next_sent: got %0d falls, want second word 0000bb at release+2",
                     fall_cyc.size());
        end
    endtask

    task automatic test_overflow();
        logic [22:0] w[17];
        int          h;
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 17; i++) begin
            w[i] = 23'(i * 3 + 100);
            push(w[i]);
            if (i == 14) begin
                n_tests++;
                if (fifo_full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_at_15: got %b, want 0", fifo_full);
                end
            end
            if (i == 15) begin
                n_tests++;
                if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_at_16: got full %b ovf %b, want 1 0", fifo_full, overflow);
                end
            end
        end
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_17: got %b, want 1", overflow);
        end
        h = cyc;
        hold = 1'b0;
        tick(16 * 3 + 10);
        n_tests++;
        if (fall_cyc.size() != 16 || overflow !== 1'b1 || fifo_full !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_drain: got %0d words ovf %b full %b, want 16 1 0",
                     fall_cyc.size(), overflow, fifo_full);
        end
        for (int i = 0; i < 16 && i < fall_dat.size(); i++) begin
            n_tests++;
            if (fall_dat[i] !== w[i]) begin
                n_fail++;
                $display("FAIL overflow_order[%0d]: got %h, want %h", i, fall_dat[i], w[i]);
            end
        end

        // Push into a full FIFO in the same cycle the head is popped.
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 16; i++) push(w[i]);
        hold = 1'b0;
        push(23'h055555);
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pushpop_ovf: got %b, want 0", overflow);
        end
        tick(17 * 3 + 10);
        n_tests++;
        if (fall_cyc.size() != 17 || fall_dat[fall_dat.size() - 1] !== 23'h055555) begin
            n_fail++;
            $display("FAIL full_pushpop_sent: got %0d words, want 17 ending with 055555", fall_cyc.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(23'h0000c1);
        push(23'h0000c2);
        tick(1);              // first word strobe cycle
        n_tests++;
        if (ds_n !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_pre: got ds_n %b, want 0", ds_n);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ds_n !== 1'b1 || word_cnt !== 16'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_now: got ds_n %b cnt %0d busy %b, want 1 0 0", ds_n, word_cnt, busy);
        end
        tick(2);
        rst_n = 1'b1;
        tick(20);
        n_tests++;
        if (fall_cyc.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_flush: got %0d strobes busy %b, want 0 0", fall_cyc.size(), busy);
        end
        push(23'h0000c3);
        tick(6);
        n_tests++;
        if (fall_cyc.size() != 1 || fall_dat[0] !== 23'h0000c3) begin
            n_fail++;
            $display("FAIL rstmid_after: got %0d strobes, want 1 carrying 0000c3", fall_cyc.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.word_cnt = 16'hfffe;
        #1;
        release dut.word_cnt;
        for (int i = 0; i < 3; i++) push(23'(i + 7));
        tick(12);
        n_tests++;
        if (word_cnt !== 16'd1 || ev_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL word_cnt_wrap: got %0d/%0d, want 1/0", word_cnt, ev_cnt);
        end
    endtask

    task automatic test_ee_back_to_back();
        int c0;
        do_reset();
        c0 = cyc;
        push(23'h600002);
        push(23'h600003);
        tick(33);             // cycle c0+35: last cycle of the second gap
        n_tests++;
        if (busy !== 1'b1 || ds_n !== 1'b1) begin
            n_fail++;
            $display("FAIL ee_gap_end: got busy %b ds_n %b, want 1 1", busy, ds_n);
        end
        tick(1);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ee_idle: got busy %b, want 0", busy);
        end
        n_tests++;
        if (fall_cyc.size() != 2 || fall_cyc[0] != c0 + 3 || fall_cyc[1] != c0 + 3 + 3 + GAP) begin
            n_fail++;
            $display("FAIL ee_spacing: got %0d strobes, want 2 at cycles 3 and %0d", fall_cyc.size(), 6 + GAP);
        end
        n_tests++;
        if (ev_cnt !== 16'd2 || word_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL ee_counts: got %0d/%0d, want 2/2", word_cnt, ev_cnt);
        end
    endtask

    task automatic test_random();
        logic [22:0] exp_q[$];
        logic [22:0] w;
        int          n_ee;
        int          min_gap;
        do_reset();
        n_ee = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) hold = ~hold;
            if ($urandom_range(0, 1) == 1 && (exp_q.size() - fall_cyc.size()) < 14) begin
                w = 23'($urandom);
                if ($urandom_range(0, 3) == 0) w[22:21] = 2'b11;
                else if (w[22:21] == 2'b11)    w[22]    = 1'b0;
                if (word_is_ee(w)) n_ee++;
                exp_q.push_back(w);
                wr_en   = 1'b1;
                wr_data = w;
            end else begin
                wr_en = 1'b0;
            end
            tick(1);
        end
        wr_en = 1'b0;
        hold  = 1'b0;
        tick(300);
        n_tests++;
        if (fall_cyc.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d strobes, want %0d", fall_cyc.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < fall_dat.size(); i++) begin
            n_tests++;
            if (fall_dat[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: got %h, want %h", i, fall_dat[i], exp_q[i]);
            end
            if (i > 0) begin
                min_gap = 3 + (word_is_ee(exp_q[i-1]) ? GAP : 0);
                n_tests++;
                if (fall_cyc[i] - fall_cyc[i-1] < min_gap) begin
                    n_fail++;
                    $display("FAIL rand_spacing[%0d]: got %0d cycles, want at least %0d",
                             i, fall_cyc[i] - fall_cyc[i-1], min_gap);
                end
            end
        end
        n_tests++;
        if (word_cnt !== 16'(exp_q.size()) || ev_cnt !== 16'(n_ee) || overflow !== 1'b0 || unstable != 0) begin
            n_fail++;
            $display("FAIL rand_totals: got cnt %0d/%0d ovf %b unstable %0d, want %0d/%0d 0 0",
                     word_cnt, ev_cnt, overflow, unstable, exp_q.size(), n_ee);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_hold();
        test_overflow();
        test_reset_mid();
        test_wrap();
        test_ee_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
